counter_sched: RTL

Programmable scheduler for a wrap-around counter datapath. It accepts a configuration (terminal count, prescale, mode) over a ready/valid handshake, then sequences the counter. It generates a prescaled count-enable tick and signals completion with a done pulse, in one-shot or periodic mode. It sits between a control/register block and any logic needing timed events (frame/line timing, periodic triggers).

---
 rtl/counter_sched.sv | 105 ++++++++++
 1 files changed

// File: rtl/counter_sched.sv
// Programmable wrap-around counter scheduler: takes period/prescale/mode over a
// ready/valid handshake, then emits prescaled ticks and a done pulse on wrap.
module counter_sched #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [WIDTH-1:0]   cfg_period,
  input  logic [PRESC_W-1:0] cfg_presc,
  input  logic               cfg_mode,
  input  logic               start,
  input  logic               stop,
  input  logic               hold,
  output logic               busy,
  output logic               tick,
  output logic [WIDTH-1:0]   cnt,
  output logic               done,
  output logic [1:0]         dbg_state
);

  // Handshake: a configuration transfers on a rising edge where
  // cfg_valid && cfg_ready; cfg_ready is low only while a run is active.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]   CNT_ONE = 1;
  localparam logic [PRESC_W-1:0] PRE_ONE = 1;

  state_t             state_q;
  logic [WIDTH-1:0]   cnt_q;
  logic [WIDTH-1:0]   period_q;
  logic [PRESC_W-1:0] pre_q;
  logic [PRESC_W-1:0] presc_q;
  logic               mode_q;
  logic               cfg_fire;
  logic               wrap;

  assign cfg_fire = cfg_valid && cfg_ready;
  // stop and hold mask the tick in the same cycle they are raised.
  assign tick     = (state_q == S_RUN) && !hold && !stop && (pre_q == presc_q);
  assign wrap     = tick && (cnt_q == period_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      pre_q    <= '0;
      period_q <= '0;
      presc_q  <= '0;
      mode_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cfg_fire) begin
            period_q <= cfg_period;
            presc_q  <= cfg_presc;
            mode_q   <= cfg_mode;
            state_q  <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (cfg_fire) begin
            period_q <= cfg_period;
            presc_q  <= cfg_presc;
            mode_q   <= cfg_mode;
          end else if (start) begin
            cnt_q   <= '0;
            pre_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (stop) begin
            state_q <= S_ARMED;
          end else if (tick) begin
            pre_q <= '0;
            if (wrap) begin
              cnt_q <= '0;
              if (!mode_q) state_q <= S_ARMED;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end else if (!hold) begin
            pre_q <= pre_q + PRE_ONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state_q == S_RUN);
  assign cfg_ready = (state_q != S_RUN);
  assign done      = wrap;
  assign cnt       = cnt_q;
  assign dbg_state = state_q;

endmodule
